// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and width defaults for the arithmetic block
package arith_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W = 4;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
  localparam int CNT_W = cnt_w(DEF_DIVIDEND_W);
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring division step (shift in a dividend bit, trial subtract)
module div_restore_step #(
  parameter int W = 4
) (
  input  logic [W:0]   rem,
  input  logic         msb,
  input  logic [W-1:0] divisor,
  output logic [W:0]   next_rem,
  output logic         q_bit
);
  logic [W:0]   shifted;
  logic [W+1:0] trial;
  always_comb begin
    shifted  = {rem[W-1:0], msb};
    trial    = {1'b0, shifted} - {2'b00, divisor};
    q_bit    = ~trial[W+1];
    next_rem = q_bit ? trial[W:0] : shifted;
  end
endmodule

// File: rtl/restoring_divider8x4.sv
// restoring_divider8x4: sequential restoring divider, one quotient bit per clock
module restoring_divider8x4
  import arith_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  localparam int CW = cnt_w(DIVIDEND_W);
  state_t                state;
  logic [DIVIDEND_W-1:0] q;
  logic [DIVISOR_W:0]    rem, next_rem;
  logic [DIVISOR_W-1:0]  dvs;
  logic [CW-1:0]         cnt;
  logic                  dbz, q_bit;
  div_restore_step #(.W(DIVISOR_W)) u_step (
    .rem(rem), .msb(q[DIVIDEND_W-1]), .divisor(dvs), .next_rem(next_rem), .q_bit(q_bit)
  );
  // a zero divisor spends one cycle in CALC so its latency is one edge past acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= '0;
      rem   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvs   <= divisor;
          cnt   <= '0;
          rem   <= '0;
          dbz   <= divisor == '0;
          q     <= divisor == '0 ? '1 : dividend;
          state <= CALC;
        end
        CALC: if (dbz) state <= DONE;
        else begin
          q     <= {q[DIVIDEND_W-2:0], q_bit};
          rem   <= next_rem;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(DIVIDEND_W - 1)) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready    = state == IDLE;
  assign out_valid   = state == DONE;
  assign quotient    = q;
  assign remainder   = rem[DIVISOR_W-1:0];
  assign div_by_zero = dbz;
endmodule

// File: tb/tb_restoring_divider8x4.sv
// tb_restoring_divider8x4: directed and exhaustive self-checking bench for the divider
module tb_restoring_divider8x4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  int checks = 0;
  int errors = 0;

  restoring_divider8x4 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic [7:0] a, input logic [3:0] b, output bit ok);
    int n;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({out_valid, quotient, remainder, div_by_zero, in_ready} !== {1'b0, 8'h00, 4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: got ov=%b q=%0d r=%0d dbz=%b ir=%b, want 0 0 0 0 1",
               out_valid, quotient, remainder, div_by_zero, in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: got ov=%b ir=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic;
    logic [7:0] a[3] = '{8'd200, 8'd255, 8'd9};
    logic [3:0] b[3] = '{4'd7, 4'd1, 4'd15};
    logic [7:0] eq[3] = '{8'd28, 8'd255, 8'd0};
    logic [3:0] er[3] = '{4'd4, 4'd0, 4'd9};
    bit ok;
    int lat;
    for (int i = 0; i < 3; i++) begin
      launch(a[i], b[i], ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL basic_accept %0d/%0d: in_ready never high", a[i], b[i]);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy %0d/%0d: in_ready=%b, want 0", a[i], b[i], in_ready);
      end
      wait_done(lat);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL basic_latency %0d/%0d: got %0d, want 8", a[i], b[i], lat);
      end
      checks++;
      if ({quotient, remainder, div_by_zero} !== {eq[i], er[i], 1'b0}) begin
        errors++;
        $display("FAIL basic_result %0d/%0d: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=0",
                 a[i], b[i], quotient, remainder, div_by_zero, eq[i], er[i]);
      end
      consume();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_return %0d/%0d: got ir=%b ov=%b, want 1 0", a[i], b[i], in_ready, out_valid);
      end
    end
  endtask

  task automatic test_div_zero;
    bit ok;
    int lat;
    launch(8'd100, 4'd0, ok);
    wait_done(lat);
    checks++;
    if (!ok || lat !== 1) begin
      errors++;
      $display("FAIL dbz_latency: got accept=%b lat=%0d, want 1 1", ok, lat);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {8'hFF, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL dbz_result: got q=%h r=%0d dbz=%b, want q=ff r=0 dbz=1", quotient, remainder, div_by_zero);
    end
    consume();
  endtask

  task automatic test_backpressure;
    bit ok;
    int lat;
    launch(8'd143, 4'd11, ok);
    wait_done(lat);
    checks++;
    if (!ok || lat !== 8) begin
      errors++;
      $display("FAIL bp_latency: got accept=%b lat=%0d, want 1 8", ok, lat);
    end
    dividend = 8'd50;
    divisor  = 4'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'd13, 4'd0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got ov=%b ir=%b q=%0d r=%0d dbz=%b, want 1 0 13 0 0",
                 i, out_valid, in_ready, quotient, remainder, div_by_zero);
      end
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ir=%b ov=%b, want 1 0", in_ready, out_valid);
    end
    launch(8'd50, 4'd5, ok);
    wait_done(lat);
    checks++;
    if (!ok || lat !== 8 || {quotient, remainder, div_by_zero} !== {8'd10, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL bp_second: got accept=%b lat=%0d q=%0d r=%0d dbz=%b, want 1 8 10 0 0",
               ok, lat, quotient, remainder, div_by_zero);
    end
    consume();
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen = 1'b0;
    int lat;
    launch(8'd77, 4'd3, ok);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, quotient, remainder, div_by_zero, in_ready} !== {1'b0, 8'h00, 4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midreset_values: got ov=%b q=%0d r=%0d dbz=%b ir=%b, want 0 0 0 0 1",
               out_valid, quotient, remainder, div_by_zero, in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
      if (i == 3) rst_n = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_result: out_valid rose=%b, want 0", seen);
    end
    launch(8'd77, 4'd3, ok);
    wait_done(lat);
    checks++;
    if (!ok || lat !== 8 || {quotient, remainder, div_by_zero} !== {8'd25, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL midreset_rerun: got accept=%b lat=%0d q=%0d r=%0d dbz=%b, want 1 8 25 2 0",
               ok, lat, quotient, remainder, div_by_zero);
    end
    consume();
  endtask

  task automatic test_back_to_back;
    bit ok;
    int lat;
    logic [7:0] eq;
    logic [3:0] er;
    out_ready = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        eq = b == 0 ? 8'hFF : 8'(a / b);
        er = b == 0 ? 4'h0 : 4'(a % b);
        launch(8'(a), 4'(b), ok);
        wait_done(lat);
        checks++;
        if (!ok || lat !== (b == 0 ? 1 : 8) || {quotient, remainder, div_by_zero} !== {eq, er, b == 0}) begin
          errors++;
          $display("FAIL sweep %0d/%0d: got accept=%b lat=%0d q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
                   a, b, ok, lat, quotient, remainder, div_by_zero, eq, er, b == 0);
        end
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
